alu_exec_unit: RTL



---
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a WIDTH-cycle shift-add multiply.
// Define ALU_FLAGS_EN to add the registered Negative/Overflow/Carry outputs.
module alu_exec_unit #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       ALUCtrl,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Busy,
   output logic             Done
`ifdef ALU_FLAGS_EN
   ,
   output logic             Negative,
   output logic             Overflow,
   output logic             Carry
`endif
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [WIDTH-1:0] single_res;
   logic             start_mul;

   function automatic logic [WIDTH-1:0] exec_op(input logic [3:0] ctrl,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] res;
      res = '0;
      case (ctrl)
         OP_AND:  res = a & b;
         OP_ORR:  res = a | b;
         OP_ADD:  res = a + b;
         OP_SUB:  res = a + ~b + WIDTH'(1);
         OP_PASS: res = b;
         default: res = '0;
      endcase
      return res;
   endfunction

`ifdef ALU_FLAGS_EN
   // Returns {overflow, carry}; subtraction carry is the A+~B+1 carry-out (1 = no borrow).
   function automatic logic [1:0] exec_flags(input logic [3:0] ctrl,
                                             input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
      logic [WIDTH:0]          sum;
      logic signed [WIDTH-1:0] res;
      logic                    c, v;
      sum = '0;
      c   = 1'b0;
      v   = 1'b0;
      if (ctrl == OP_ADD) begin
         sum = {1'b0, a} + {1'b0, b};
         res = $signed(sum[WIDTH-1:0]);
         c   = sum[WIDTH];
         v   = ((a < 0) == (b < 0)) && ((res < 0) != (a < 0));
      end else if (ctrl == OP_SUB) begin
         sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
         res = $signed(sum[WIDTH-1:0]);
         c   = sum[WIDTH];
         v   = ((a < 0) != (b < 0)) && ((res < 0) != (a < 0));
      end
      return {v, c};
   endfunction

   logic [1:0] single_flags;
   assign single_flags = exec_flags(ALUCtrl, BusA, BusB);
`endif

   assign single_res = exec_op(ALUCtrl, BusA, BusB);
   assign start_mul  = (state == IDLE) && Start && (ALUCtrl == OP_MUL);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_mul) state_nxt = MUL;
         MUL:     if (cnt == CNT_LAST) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and result registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         BusW  <= '0;
         Zero  <= 1'b1;
         Busy  <= 1'b0;
         Done  <= 1'b0;
`ifdef ALU_FLAGS_EN
         Negative <= 1'b0;
         Overflow <= 1'b0;
         Carry    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         Busy  <= (state == MUL);
         Done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mul) begin
                  cnt <= '0;
               end else if (Start) begin
                  BusW <= single_res;
                  Zero <= (single_res == '0);
                  Done <= 1'b1;
`ifdef ALU_FLAGS_EN
                  Negative <= single_res[WIDTH-1];
                  Overflow <= single_flags[1];
                  Carry    <= single_flags[0];
`endif
               end
            end
            MUL: cnt <= cnt + CNT_W'(1);
            FIN: begin
               BusW <= acc;
               Zero <= (acc == '0);
               Done <= 1'b1;
`ifdef ALU_FLAGS_EN
               Negative <= acc[WIDTH-1];
               Overflow <= 1'b0;
               Carry    <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   // Multiply datapath: operands latched on start, product accumulated mod 2^WIDTH
   always_ff @(posedge CLK) begin
      if (start_mul) begin
         mcand  <= BusA;
         mplier <= BusB;
         acc    <= '0;
      end else if (state == MUL) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule
